// File: rtl/branch_resolve_update_if.sv
// Bundle of EX-stage resolution inputs and predictor-training outputs.
// master drives the EX-side inputs and observes the training/flush outputs.
// slave is the resolve block itself, which consumes EX inputs and drives the outputs.
interface branch_resolve_update_if #(
    parameter int PHT_IDX_W = 11,
    parameter int CNT_W     = 16
);
    logic                 Stall;
    logic                 EX_Valid;
    logic                 EX_Cond;
    logic                 EX_JAL;
    logic                 EX_JALR;
    logic                 EX_RET;
    logic                 EX_CALL;
    logic [31:0]          EX_PC;
    logic                 EX_Actual_Taken;
    logic [31:0]          EX_Actual_Target;
    logic                 EX_Pred_Taken;
    logic [31:0]          EX_Pred_Target;
    logic                 EX_BTB_Hit;
    logic [PHT_IDX_W-1:0] EX_PHT_Index;
    logic [1:0]           EX_PHT_Data;

    logic [PHT_IDX_W-1:0] PHT_Write_Index;
    logic [1:0]           PHT_Write_Data;
    logic                 PHT_Write_En;
    logic                 GHR_Write_Data;
    logic                 GHR_Write_En;
    logic [31:0]          BTB_Write_Addr;
    logic [31:0]          BTB_Write_Data;
    logic                 BTB_Write_En;
    logic                 RAS_RET_Inst_EX;
    logic                 RAS_CALL_Inst;
    logic [31:0]          RAS_CALL_Inst_nextPC;
    logic                 Branch_Taken__EX_MEM;
    logic                 Mispredict;
    logic [31:0]          Redirect_PC;
    logic                 Flush;
    logic [CNT_W-1:0]     Branch_Count;
    logic [CNT_W-1:0]     Mispredict_Count;

    modport master (
        output Stall, EX_Valid, EX_Cond, EX_JAL, EX_JALR, EX_RET, EX_CALL, EX_PC,
               EX_Actual_Taken, EX_Actual_Target, EX_Pred_Taken, EX_Pred_Target,
               EX_BTB_Hit, EX_PHT_Index, EX_PHT_Data,
        input  PHT_Write_Index, PHT_Write_Data, PHT_Write_En, GHR_Write_Data, GHR_Write_En,
               BTB_Write_Addr, BTB_Write_Data, BTB_Write_En, RAS_RET_Inst_EX, RAS_CALL_Inst,
               RAS_CALL_Inst_nextPC, Branch_Taken__EX_MEM, Mispredict, Redirect_PC, Flush,
               Branch_Count, Mispredict_Count
    );

    modport slave (
        input  Stall, EX_Valid, EX_Cond, EX_JAL, EX_JALR, EX_RET, EX_CALL, EX_PC,
               EX_Actual_Taken, EX_Actual_Target, EX_Pred_Taken, EX_Pred_Target,
               EX_BTB_Hit, EX_PHT_Index, EX_PHT_Data,
        output PHT_Write_Index, PHT_Write_Data, PHT_Write_En, GHR_Write_Data, GHR_Write_En,
               BTB_Write_Addr, BTB_Write_Data, BTB_Write_En, RAS_RET_Inst_EX, RAS_CALL_Inst,
               RAS_CALL_Inst_nextPC, Branch_Taken__EX_MEM, Mispredict, Redirect_PC, Flush,
               Branch_Count, Mispredict_Count
    );
endinterface

// File: rtl/branch_resolve_update.sv
// EX branch resolution: trains PHT/GHR/BTB/RAS, detects mispredicts, runs flush FSM, keeps stats.
// Latency: every output is registered, one cycle after the capturing EX cycle; 1 capture/cycle.
// Backpressure: Stall or an active flush blocks capture; flush length is fixed and never stretched.
// Ports: CLK, RST (async, active-high) plus the slave side of branch_resolve_update_if.
module branch_resolve_update #(
    parameter int PHT_IDX_W    = 11,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input logic                    CLK,
    input logic                    RST,
    branch_resolve_update_if.slave bus
);
    localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_FLUSH = 1'b1;

    logic [0:0]           state_q, state_d;
    logic [FC_W-1:0]      fcnt_q, fcnt_d;
    logic                 pht_we_q, pht_we_d, ghr_we_q, ghr_we_d, ghr_dat_q, ghr_dat_d;
    logic [PHT_IDX_W-1:0] pht_idx_q, pht_idx_d;
    logic [1:0]           pht_dat_q, pht_dat_d;
    logic                 btb_we_q, btb_we_d, ret_q, ret_d, call_q, call_d;
    logic [31:0]          btb_addr_q, btb_addr_d, btb_dat_q, btb_dat_d, npc_q, npc_d;
    logic                 bt_q, bt_d, mis_q, mis_d;
    logic [31:0]          redir_q, redir_d;
    logic [CNT_W-1:0]     bcnt_q, bcnt_d, mcnt_q, mcnt_d;

    logic        cap, ctl, act_tk, tgt_ne, mis, btb_we;
    logic [1:0]  btb_type, pht_next;
    logic [31:0] pc_plus4;

    always_comb begin
        cap      = bus.EX_Valid & ~bus.Stall & (state_q == S_IDLE);
        ctl      = bus.EX_Cond | bus.EX_JAL | bus.EX_JALR;
        act_tk   = ctl & bus.EX_Actual_Taken;
        tgt_ne   = bus.EX_Pred_Target != bus.EX_Actual_Target;
        // A prediction is wrong on direction, or right on "taken" but to the wrong place.
        mis      = (bus.EX_Pred_Taken != act_tk) | (bus.EX_Pred_Taken & act_tk & tgt_ne);
        // Returns are predicted by the RAS, so a stale BTB target on a RET is not rewritten.
        btb_we   = act_tk & (~bus.EX_BTB_Hit | (~bus.EX_RET & tgt_ne));
        btb_type = bus.EX_RET ? 2'b11 : bus.EX_JALR ? 2'b10 : bus.EX_JAL ? 2'b01 : 2'b00;
        pc_plus4 = bus.EX_PC + 32'd4;
        if (bus.EX_Actual_Taken) pht_next = (bus.EX_PHT_Data == 2'b11) ? 2'b11 : bus.EX_PHT_Data + 2'b01;
        else                     pht_next = (bus.EX_PHT_Data == 2'b00) ? 2'b00 : bus.EX_PHT_Data - 2'b01;
    end

    always_comb begin
        state_d    = state_q;
        fcnt_d     = fcnt_q;
        pht_we_d   = 1'b0;
        ghr_we_d   = 1'b0;
        btb_we_d   = 1'b0;
        ret_d      = 1'b0;
        call_d     = 1'b0;
        mis_d      = 1'b0;
        pht_idx_d  = pht_idx_q;
        pht_dat_d  = pht_dat_q;
        ghr_dat_d  = ghr_dat_q;
        btb_addr_d = btb_addr_q;
        btb_dat_d  = btb_dat_q;
        npc_d      = npc_q;
        bt_d       = bt_q;
        redir_d    = redir_q;
        bcnt_d     = bcnt_q;
        mcnt_d     = mcnt_q;

        if (cap) begin
            pht_we_d = bus.EX_Cond;
            ghr_we_d = bus.EX_Cond;
            if (bus.EX_Cond) begin
                pht_idx_d = bus.EX_PHT_Index;
                pht_dat_d = pht_next;
                ghr_dat_d = bus.EX_Actual_Taken;
            end
            btb_we_d = btb_we;
            if (btb_we) begin
                btb_addr_d = bus.EX_PC;
                btb_dat_d  = {bus.EX_Actual_Target[31:2], btb_type};
            end
            ret_d  = bus.EX_RET;
            call_d = bus.EX_CALL;
            if (bus.EX_CALL) npc_d = pc_plus4;
            bt_d    = act_tk;
            mis_d   = mis;
            redir_d = act_tk ? {bus.EX_Actual_Target[31:2], 2'b00} : pc_plus4;
            if (ctl && (bcnt_q != {CNT_W{1'b1}})) bcnt_d = bcnt_q + CNT_W'(1);
            if (mis && (mcnt_q != {CNT_W{1'b1}})) mcnt_d = mcnt_q + CNT_W'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (cap && mis) begin
                    state_d = S_FLUSH;
                    fcnt_d  = FC_W'(FLUSH_CYCLES - 1);
                end
            end
            default: begin
                // Counter runs regardless of Stall so the flush window is fixed length.
                if (fcnt_q == '0) state_d = S_IDLE;
                else              fcnt_d  = fcnt_q - FC_W'(1);
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= S_IDLE;
            fcnt_q     <= '0;
            pht_we_q   <= 1'b0;
            ghr_we_q   <= 1'b0;
            btb_we_q   <= 1'b0;
            ret_q      <= 1'b0;
            call_q     <= 1'b0;
            mis_q      <= 1'b0;
            pht_idx_q  <= '0;
            pht_dat_q  <= '0;
            ghr_dat_q  <= 1'b0;
            btb_addr_q <= '0;
            btb_dat_q  <= '0;
            npc_q      <= '0;
            bt_q       <= 1'b0;
            redir_q    <= '0;
            bcnt_q     <= '0;
            mcnt_q     <= '0;
        end else begin
            state_q    <= state_d;
            fcnt_q     <= fcnt_d;
            pht_we_q   <= pht_we_d;
            ghr_we_q   <= ghr_we_d;
            btb_we_q   <= btb_we_d;
            ret_q      <= ret_d;
            call_q     <= call_d;
            mis_q      <= mis_d;
            pht_idx_q  <= pht_idx_d;
            pht_dat_q  <= pht_dat_d;
            ghr_dat_q  <= ghr_dat_d;
            btb_addr_q <= btb_addr_d;
            btb_dat_q  <= btb_dat_d;
            npc_q      <= npc_d;
            bt_q       <= bt_d;
            redir_q    <= redir_d;
            bcnt_q     <= bcnt_d;
            mcnt_q     <= mcnt_d;
        end
    end

    assign bus.PHT_Write_Index      = pht_idx_q;
    assign bus.PHT_Write_Data       = pht_dat_q;
    assign bus.PHT_Write_En         = pht_we_q;
    assign bus.GHR_Write_Data       = ghr_dat_q;
    assign bus.GHR_Write_En         = ghr_we_q;
    assign bus.BTB_Write_Addr       = btb_addr_q;
    assign bus.BTB_Write_Data       = btb_dat_q;
    assign bus.BTB_Write_En         = btb_we_q;
    assign bus.RAS_RET_Inst_EX      = ret_q;
    assign bus.RAS_CALL_Inst        = call_q;
    assign bus.RAS_CALL_Inst_nextPC = npc_q;
    assign bus.Branch_Taken__EX_MEM = bt_q;
    assign bus.Mispredict           = mis_q;
    assign bus.Redirect_PC          = redir_q;
    // Flush comes straight off the state flop so RST drops it immediately.
    assign bus.Flush                = (state_q == S_FLUSH);
    assign bus.Branch_Count         = bcnt_q;
    assign bus.Mispredict_Count     = mcnt_q;
endmodule

// File: tb/tb_branch_resolve_update.sv
module tb_branch_resolve_update;
    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    branch_resolve_update_if #(.PHT_IDX_W(11), .CNT_W(16)) bus ();
    branch_resolve_update_if #(.PHT_IDX_W(11), .CNT_W(2))  bus2 ();

    branch_resolve_update #(.PHT_IDX_W(11), .FLUSH_CYCLES(2), .CNT_W(16)) dut (
        .CLK(CLK), .RST(RST), .bus(bus));
    branch_resolve_update #(.PHT_IDX_W(11), .FLUSH_CYCLES(2), .CNT_W(2)) dut2 (
        .CLK(CLK), .RST(RST), .bus(bus2));

    // Small-counter instance sees identical stimulus.
    assign bus2.Stall            = bus.Stall;
    assign bus2.EX_Valid         = bus.EX_Valid;
    assign bus2.EX_Cond          = bus.EX_Cond;
    assign bus2.EX_JAL           = bus.EX_JAL;
    assign bus2.EX_JALR          = bus.EX_JALR;
    assign bus2.EX_RET           = bus.EX_RET;
    assign bus2.EX_CALL          = bus.EX_CALL;
    assign bus2.EX_PC            = bus.EX_PC;
    assign bus2.EX_Actual_Taken  = bus.EX_Actual_Taken;
    assign bus2.EX_Actual_Target = bus.EX_Actual_Target;
    assign bus2.EX_Pred_Taken    = bus.EX_Pred_Taken;
    assign bus2.EX_Pred_Target   = bus.EX_Pred_Target;
    assign bus2.EX_BTB_Hit       = bus.EX_BTB_Hit;
    assign bus2.EX_PHT_Index     = bus.EX_PHT_Index;
    assign bus2.EX_PHT_Data      = bus.EX_PHT_Data;

    typedef struct packed {
        logic valid, stall, cond, jal, jalr, ret, call;
        logic [31:0] pc;
        logic tk;
        logic [31:0] tgt;
        logic ptk;
        logic [31:0] ptgt;
        logic hit;
        logic [1:0] pd;
        logic [10:0] idx;
    } stim_t;

    typedef struct packed {
        int cyc;
        int tag;
        logic pht_en;
        logic [10:0] pht_idx;
        logic [1:0] pht_dat;
        logic ghr_en, ghr_dat, btb_en;
        logic [31:0] btb_addr, btb_dat;
        logic ret, call;
        logic [31:0] npc;
        logic mis;
        logic [31:0] redir;
        logic flush;
        logic [15:0] bc, mc;
        logic bt;
        logic chk2;
        logic [1:0] bc2;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input int tag, input string f, input logic [31:0] a, input logic [31:0] x);
        n_vec++;
        if (a !== x) begin
            n_err++;
            $display("FAIL v%0d.%s: got %h, expected %h", tag, f, a, x);
        end
    endtask

    // Monitor: whenever an expected response is due, compare the DUT outputs to it.
    initial begin
        forever begin
            @(negedge CLK);
            while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
                exp_t e;
                e = exp_q.pop_front();
                chk(e.tag, "due_cycle", 32'(cyc), 32'(e.cyc));
                chk(e.tag, "pht_en", 32'(bus.PHT_Write_En), 32'(e.pht_en));
                if (e.pht_en) begin
                    chk(e.tag, "pht_idx", 32'(bus.PHT_Write_Index), 32'(e.pht_idx));
                    chk(e.tag, "pht_dat", 32'(bus.PHT_Write_Data), 32'(e.pht_dat));
                end
                chk(e.tag, "ghr_en", 32'(bus.GHR_Write_En), 32'(e.ghr_en));
                if (e.ghr_en) chk(e.tag, "ghr_dat", 32'(bus.GHR_Write_Data), 32'(e.ghr_dat));
                chk(e.tag, "btb_en", 32'(bus.BTB_Write_En), 32'(e.btb_en));
                if (e.btb_en) begin
                    chk(e.tag, "btb_addr", bus.BTB_Write_Addr, e.btb_addr);
                    chk(e.tag, "btb_dat", bus.BTB_Write_Data, e.btb_dat);
                end
                chk(e.tag, "ras_ret", 32'(bus.RAS_RET_Inst_EX), 32'(e.ret));
                chk(e.tag, "ras_call", 32'(bus.RAS_CALL_Inst), 32'(e.call));
                if (e.call) chk(e.tag, "ras_npc", bus.RAS_CALL_Inst_nextPC, e.npc);
                chk(e.tag, "mispredict", 32'(bus.Mispredict), 32'(e.mis));
                if (e.mis) chk(e.tag, "redirect", bus.Redirect_PC, e.redir);
                chk(e.tag, "flush", 32'(bus.Flush), 32'(e.flush));
                chk(e.tag, "branch_cnt", 32'(bus.Branch_Count), 32'(e.bc));
                chk(e.tag, "mispred_cnt", 32'(bus.Mispredict_Count), 32'(e.mc));
                chk(e.tag, "br_taken", 32'(bus.Branch_Taken__EX_MEM), 32'(e.bt));
                if (e.chk2) chk(e.tag, "branch_cnt_w2", 32'(bus2.Branch_Count), 32'(e.bc2));
            end
        end
    end

    task automatic drive(input stim_t s);
        bus.EX_Valid = s.valid; bus.Stall = s.stall;
        bus.EX_Cond = s.cond; bus.EX_JAL = s.jal; bus.EX_JALR = s.jalr;
        bus.EX_RET = s.ret; bus.EX_CALL = s.call; bus.EX_PC = s.pc;
        bus.EX_Actual_Taken = s.tk; bus.EX_Actual_Target = s.tgt;
        bus.EX_Pred_Taken = s.ptk; bus.EX_Pred_Target = s.ptgt; bus.EX_BTB_Hit = s.hit;
        bus.EX_PHT_Data = s.pd; bus.EX_PHT_Index = s.idx;
    endtask

    // cls = {cond, jal, jalr, ret, call}
    function automatic stim_t mk(input logic [4:0] cls, input logic [31:0] pc, input logic tk,
                                 input logic [31:0] tgt, input logic ptk, input logic [31:0] ptgt,
                                 input logic hit, input logic [1:0] pd, input logic [10:0] idx);
        stim_t s;
        s = '0;
        s.valid = 1'b1;
        {s.cond, s.jal, s.jalr, s.ret, s.call} = cls;
        s.pc = pc; s.tk = tk; s.tgt = tgt; s.ptk = ptk; s.ptgt = ptgt;
        s.hit = hit; s.pd = pd; s.idx = idx;
        return s;
    endfunction

    function automatic exp_t qt(input logic [15:0] bc, input logic [15:0] mc, input logic fl, input logic bt);
        exp_t e;
        e = '0;
        e.bc = bc; e.mc = mc; e.flush = fl; e.bt = bt;
        return e;
    endfunction

    // Drive one EX cycle and queue the response due on the following cycle.
    task automatic issue(input int tag, input stim_t s, input exp_t e);
        @(posedge CLK);
        #1;
        drive(s);
        e.cyc = cyc + 1;
        e.tag = tag;
        exp_q.push_back(e);
    endtask

    initial begin
        stim_t s, idle, bad;
        exp_t  e;
        idle = '0;
        // Mispredicting conditional used as wrong-path / stalled traffic.
        bad = mk(5'b10000, 32'h0000_0AA0, 1'b0, 32'h0, 1'b1, 32'h0000_0BB0, 1'b1, 2'b10, 11'd1);
        drive(idle);

        repeat (2) @(posedge CLK);
        #1;
        e = '0; e.cyc = cyc; e.tag = 0; e.chk2 = 1'b1;
        exp_q.push_back(e);
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b0;

        issue(1, idle, qt(0, 0, 0, 0));

        // Cond, weakly-not-taken, actually taken: train up, install BTB, flush.
        s = mk(5'b10000, 32'h100, 1'b1, 32'h200, 1'b0, 32'h0, 1'b0, 2'b01, 11'd5);
        e = qt(1, 1, 1, 1);
        e.pht_en = 1; e.pht_idx = 11'd5; e.pht_dat = 2'b10; e.ghr_en = 1; e.ghr_dat = 1;
        e.btb_en = 1; e.btb_addr = 32'h100; e.btb_dat = 32'h200; e.mis = 1; e.redir = 32'h200;
        issue(2, s, e);
        // Wrong-path instructions during flush, stall toggling.
        issue(3, bad, qt(1, 1, 1, 1));
        s = bad; s.stall = 1'b1;
        issue(4, s, qt(1, 1, 0, 1));

        // Strongly-taken, correct: saturates at 11, BTB already right.
        s = mk(5'b10000, 32'h120, 1'b1, 32'h400, 1'b1, 32'h400, 1'b1, 2'b11, 11'd7);
        e = qt(2, 1, 0, 1);
        e.pht_en = 1; e.pht_idx = 11'd7; e.pht_dat = 2'b11; e.ghr_en = 1; e.ghr_dat = 1;
        issue(5, s, e);

        // Strongly-not-taken, correct: saturates at 00.
        s = mk(5'b10000, 32'h130, 1'b0, 32'h200, 1'b0, 32'h0, 1'b0, 2'b00, 11'd9);
        e = qt(3, 1, 0, 0);
        e.pht_en = 1; e.pht_idx = 11'd9; e.pht_dat = 2'b00; e.ghr_en = 1; e.ghr_dat = 0;
        issue(6, s, e);

        // JAL CALL at top of address space: return address wraps to 0.
        s = mk(5'b01001, 32'hFFFF_FFFC, 1'b1, 32'h40, 1'b1, 32'h40, 1'b0, 2'b00, 11'd0);
        e = qt(4, 1, 0, 1);
        e.btb_en = 1; e.btb_addr = 32'hFFFF_FFFC; e.btb_dat = 32'h41; e.call = 1; e.npc = 32'h0;
        issue(7, s, e);

        // Ordinary non-control instruction, nothing predicted.
        s = mk(5'b00000, 32'h140, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 2'b00, 11'd0);
        issue(8, s, qt(4, 1, 0, 0));

        // RET with wrong RAS target: mispredict, no BTB rewrite.
        s = mk(5'b00110, 32'h500, 1'b1, 32'h304, 1'b1, 32'h300, 1'b1, 2'b00, 11'd0);
        e = qt(5, 2, 1, 1);
        e.ret = 1; e.mis = 1; e.redir = 32'h304;
        issue(9, s, e);
        issue(10, idle, qt(5, 2, 1, 1));
        issue(11, idle, qt(5, 2, 0, 1));

        // BTB alias on a non-control instruction (Actual_Taken noise must be ignored).
        s = mk(5'b00000, 32'h600, 1'b1, 32'h999, 1'b1, 32'h700, 1'b1, 2'b00, 11'd0);
        e = qt(5, 3, 1, 0);
        e.mis = 1; e.redir = 32'h604;
        issue(12, s, e);
        issue(13, idle, qt(5, 3, 1, 0));
        issue(14, idle, qt(5, 3, 0, 0));

        // JALR with a new target (low bits set): BTB rewritten with type 10.
        s = mk(5'b00100, 32'h700, 1'b1, 32'h803, 1'b1, 32'h700, 1'b1, 2'b00, 11'd0);
        e = qt(6, 4, 1, 1);
        e.btb_en = 1; e.btb_addr = 32'h700; e.btb_dat = 32'h802; e.mis = 1; e.redir = 32'h800;
        issue(15, s, e);
        issue(16, idle, qt(6, 4, 1, 1));
        issue(17, idle, qt(6, 4, 0, 1));

        // Capture followed by a stalled cycle: strobes pulse exactly once.
        s = mk(5'b10000, 32'h150, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 2'b10, 11'd3);
        e = qt(7, 4, 0, 0);
        e.pht_en = 1; e.pht_idx = 11'd3; e.pht_dat = 2'b01; e.ghr_en = 1; e.ghr_dat = 0;
        issue(18, s, e);
        s = bad; s.stall = 1'b1;
        issue(19, s, qt(7, 4, 0, 0));
        issue(20, idle, qt(7, 4, 0, 0));

        // Mispredict, then reset in the middle of the flush window.
        s = mk(5'b00000, 32'h10, 1'b0, 32'h0, 1'b1, 32'h80, 1'b1, 2'b00, 11'd0);
        e = qt(7, 5, 1, 0);
        e.mis = 1; e.redir = 32'h14;
        issue(21, s, e);
        @(posedge CLK);
        #1;
        drive(idle);
        @(posedge CLK);
        #2;
        RST = 1'b1;
        e = '0; e.cyc = cyc; e.tag = 22; e.chk2 = 1'b1;
        exp_q.push_back(e);
        @(posedge CLK);
        #3;
        RST = 1'b0;

        // Five correct control-flow captures: 16-bit counter 5, 2-bit counter pins at 3.
        for (int k = 1; k <= 5; k++) begin
            s = mk(5'b10000, 32'h1000 + 32'(k * 4), 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 2'b01, 11'(k));
            e = qt(16'(k), 0, 0, 0);
            e.pht_en = 1; e.pht_idx = 11'(k); e.pht_dat = 2'b00; e.ghr_en = 1; e.ghr_dat = 0;
            e.chk2 = 1; e.bc2 = (k >= 3) ? 2'd3 : 2'(k);
            issue(22 + k, s, e);
        end
        issue(28, idle, qt(5, 0, 0, 0));

        for (int w = 0; w < 20 && exp_q.size() > 0; w++) @(posedge CLK);
        if (exp_q.size() > 0) begin
            n_vec++;
            n_err++;
            $display("FAIL drain: %0d responses still pending, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, expected completion");
        $fatal(1);
    end
endmodule

// File: doc/branch_resolve_update.md
Name: branch_resolve_update

Overview:
- EX-stage branch resolution and predictor-training block; sits directly upstream of the branch prediction unit and drives all of its PHT/GHR/BTB/RAS update ports.
- Compares the fetch-time prediction, carried down the pipe, against the actual EX outcome.
- Issues registered one-cycle training strobes, detects mispredicts, and runs a flush/redirect FSM.
- Keeps saturating branch and mispredict statistics counters.

Parameters:
- PHT_IDX_W, 11, width of PHT index.
- FLUSH_CYCLES, 2, cycles Flush stays high per mispredict (>=1).
- CNT_W, 16, width of statistics counters.

Ports:
- CLK in 1: clock.
- RST in 1: reset; the only clock is CLK, and RST is asynchronous, active-high.
- Stall in 1: pipeline stall; while high, no EX instruction is captured.
- EX_Valid in 1: EX holds a valid instruction.
- EX_Cond/EX_JAL/EX_JALR/EX_RET/EX_CALL in 1 each: instruction class; RET and CALL are qualifiers on JALR/JAL.
- EX_PC in 32: instruction PC.
- EX_Actual_Taken in 1, EX_Actual_Target in 32: resolved outcome.
- EX_Pred_Taken in 1, EX_Pred_Target in 32, EX_BTB_Hit in 1: fetch-time prediction.
- EX_PHT_Index in PHT_IDX_W, EX_PHT_Data in 2: PHT index and counter read at fetch.
- PHT_Write_Index out PHT_IDX_W, PHT_Write_Data out 2, PHT_Write_En out 1.
- GHR_Write_Data out 1, GHR_Write_En out 1.
- BTB_Write_Addr out 32, BTB_Write_Data out 32, BTB_Write_En out 1.
- RAS_RET_Inst_EX out 1, RAS_CALL_Inst out 1, RAS_CALL_Inst_nextPC out 32.
- Branch_Taken__EX_MEM out 1: registered actual-taken of the last captured instruction.
- Mispredict out 1, Redirect_PC out 32, Flush out 1.
- Branch_Count out CNT_W, Mispredict_Count out CNT_W.

Behaviour:
- Reset: all outputs 0; FSM = IDLE; flush counter = 0.
- Capture: cap = EX_Valid & ~Stall & (state==IDLE). Resolution happens in cycle N; every output below is registered and appears in N+1.
- Strobes (PHT_Write_En, GHR_Write_En, BTB_Write_En, RAS_*, Mispredict) are single-cycle pulses. They are 0 in any cycle not following a cap.
- Address/data outputs hold their last value between captures.
- ctl = Cond|JAL|JALR.
- PHT update (Cond only):
  - Index = EX_PHT_Index.
  - Data = taken ? min(EX_PHT_Data+1, 3) : max(EX_PHT_Data-1, 0). Saturating 2-bit arithmetic; never wraps.
- GHR update (Cond only): GHR_Write_Data = EX_Actual_Taken.
- BTB write:
  - Condition: ctl & Actual_Taken & (~EX_BTB_Hit | (~RET & Pred_Target != Actual_Target)).
  - Addr = EX_PC.
  - Data = {Actual_Target[31:2], type}. type = 00 Cond, 01 JAL, 10 JALR, 11 RET; RET takes priority over JALR.
- RAS:
  - RAS_CALL_Inst pulses on a captured CALL; RAS_CALL_Inst_nextPC = EX_PC+4, with 32-bit wrap.
  - RAS_RET_Inst_EX pulses on a captured RET.
- Branch_Taken__EX_MEM = ctl & Actual_Taken on each cap; holds otherwise.
- Mispredict condition:
  - (Pred_Taken != (ctl & Actual_Taken)) | (Pred_Taken & Actual_Taken & ctl & Pred_Target != Actual_Target).
  - A non-control instruction with Pred_Taken=1 (BTB alias) is a mispredict that makes no PHT/BTB/GHR update.
- Redirect_PC = (ctl & Actual_Taken) ? {Actual_Target[31:2],2'b00} : EX_PC+4.
- FSM:
  - IDLE -> FLUSH on a mispredict cap. The flush counter loads FLUSH_CYCLES-1 and Flush=1 starting in N+1.
  - FLUSH: Flush=1 and the counter decrements every cycle, including stall cycles. At 0, return to IDLE (Flush=0 the next cycle).
  - Flush is high for exactly FLUSH_CYCLES cycles.
  - While in FLUSH, EX_Valid is ignored (wrong-path): no strobes, no counter increments.
- Counters (saturate at 2^CNT_W-1, never wrap):
  - Branch_Count +1 per cap with ctl.
  - Mispredict_Count +1 per cap with a mispredict.
- Stall during FLUSH does not extend Flush. Stall in IDLE blocks capture only; pending outputs from a previous cap still pulse exactly once.
- RST mid-FLUSH: Flush drops asynchronously, FSM goes to IDLE, counters clear.
- Back-to-back captures in consecutive cycles are each fully processed (throughput 1/cycle).

Test Plan:
- Cond at PC=0x100, PHT_Data=2'b01, Pred_Taken=0, Actual_Taken=1, target 0x200, BTB_Hit=0 -> N+1:
  - PHT_Write_Data=2'b10, GHR_Write_Data=1, BTB_Write_Data=0x00000200, BTB_Write_Addr=0x100.
  - Mispredict=1, Redirect_PC=0x200, Flush high 2 cycles, Mispredict_Count=1.
- Cond, PHT_Data=2'b11, taken, predicted correctly, BTB_Hit=1 with same target -> PHT_Write_Data=2'b11 (saturate), no BTB write, no Flush. Repeat with PHT_Data=00, not taken -> 2'b00.
- JAL CALL at PC=0xFFFFFFFC, target 0x40, BTB_Hit=0 -> RAS_CALL_Inst pulse, nextPC=0x00000000 (wrap), BTB_Write_Data=0x00000041, no PHT/GHR write.
- RET, Pred_Taken=1, Pred_Target=0x300, Actual 0x304, BTB_Hit=1 -> RAS_RET_Inst_EX pulse, no BTB write, Mispredict=1, Redirect_PC=0x304.
- Mispredict, then EX_Valid mispredicting instructions during both Flush cycles, Stall toggling -> Flush exactly 2 cycles, no further strobes, Mispredict_Count=1.
- Assert RST during FLUSH -> Flush=0 immediately (asynchronous), counters 0; with CNT_W=2, five control-flow captures -> Branch_Count=3.
